// File: rtl/digit_text_renderer_pkg.sv
// digit_text_renderer_pkg: glyph codes and cell geometry shared by the renderer and its glyph ROM
package digit_text_renderer_pkg;
    localparam logic [3:0] GLYPH_0     = 4'd0;
    localparam logic [3:0] GLYPH_1     = 4'd1;
    localparam logic [3:0] GLYPH_2     = 4'd2;
    localparam logic [3:0] GLYPH_3     = 4'd3;
    localparam logic [3:0] GLYPH_4     = 4'd4;
    localparam logic [3:0] GLYPH_5     = 4'd5;
    localparam logic [3:0] GLYPH_6     = 4'd6;
    localparam logic [3:0] GLYPH_7     = 4'd7;
    localparam logic [3:0] GLYPH_8     = 4'd8;
    localparam logic [3:0] GLYPH_9     = 4'd9;
    localparam logic [3:0] GLYPH_MINUS = 4'd10;
    localparam logic [3:0] GLYPH_DOT   = 4'd11;
    localparam logic [3:0] GLYPH_E     = 4'd12;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;
    localparam int GLYPH_W   = 5;
    localparam int GLYPH_H   = 6;
    localparam int CELL      = 8;
    localparam int CELL_LOG2 = 3;
endpackage

// File: rtl/digit_text_renderer_if.sv
// digit_text_renderer_if: pixel stream, buffer write port and cursor controls of the text renderer
interface digit_text_renderer_if #(
    parameter int N_CHARS = 8
);
    localparam int AW = $clog2(N_CHARS);
    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic          video_on;
    logic          frame_tick;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          cursor_en;
    logic [AW-1:0] cursor_pos;
    logic          pixel_on;
    logic          video_on_d;
    modport master (
        output pixel_x, pixel_y, video_on, frame_tick, wr_en, wr_addr, wr_data, cursor_en, cursor_pos,
        input  pixel_on, video_on_d
    );
    modport slave (
        input  pixel_x, pixel_y, video_on, frame_tick, wr_en, wr_addr, wr_data, cursor_en, cursor_pos,
        output pixel_on, video_on_d
    );
endinterface

// File: rtl/digit_text_renderer_glyph_rom.sv
// glyph_rom_5x6: combinational 5x6 font; rows 6-7 and blank codes read as zero, MSB is the leftmost column
module glyph_rom_5x6
    import digit_text_renderer_pkg::*;
(
    input  logic [3:0]         code,
    input  logic [2:0]         row,
    output logic [GLYPH_W-1:0] bits
);
    localparam logic [4:0] FONT [16][8] = '{
        '{5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E, 5'h00, 5'h00},
        '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h0E, 5'h00, 5'h00},
        '{5'h0E, 5'h11, 5'h02, 5'h04, 5'h08, 5'h1F, 5'h00, 5'h00},
        '{5'h1E, 5'h01, 5'h0E, 5'h01, 5'h01, 5'h1E, 5'h00, 5'h00},
        '{5'h02, 5'h06, 5'h0A, 5'h1F, 5'h02, 5'h02, 5'h00, 5'h00},
        '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h11, 5'h0E, 5'h00, 5'h00},
        '{5'h0E, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E, 5'h00, 5'h00},
        '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h00, 5'h00},
        '{5'h0E, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E, 5'h00, 5'h00},
        '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h0E, 5'h00, 5'h00},
        '{5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00},
        '{5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h0C, 5'h00, 5'h00},
        '{5'h1F, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F, 5'h00, 5'h00},
        '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00},
        '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00},
        '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}
    };
    assign bits = FONT[code][row];
endmodule

// File: rtl/digit_text_renderer.sv
// digit_text_renderer: two-stage pipeline drawing a row of scaled 5x6 glyphs plus a blinking underline cursor
module digit_text_renderer
    import digit_text_renderer_pkg::*;
#(
    parameter int  N_CHARS      = 8,
    parameter int  SCALE_LOG2   = 1,
    parameter int  ORIGIN_X     = 16,
    parameter int  ORIGIN_Y     = 16,
    parameter int  BLINK_FRAMES = 30,
    localparam int AW           = $clog2(N_CHARS)
) (
    input logic                  clk,
    input logic                  reset,
    digit_text_renderer_if.slave bus
);
    localparam logic [31:0] X0    = 32'(ORIGIN_X);
    localparam logic [31:0] Y0    = 32'(ORIGIN_Y);
    localparam logic [31:0] X_END = 32'(ORIGIN_X + ((N_CHARS * CELL) << SCALE_LOG2));
    localparam logic [31:0] Y_END = 32'(ORIGIN_Y + (CELL << SCALE_LOG2));
    localparam int          BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [31:0]        w_px;
    logic [31:0]        w_py;
    logic               w_in_box;
    logic [9:0]         r_rel_x;
    logic [9:0]         r_rel_y;
    logic               r_in_box;
    logic               r_vid;
    logic [AW-1:0]      w_idx;
    logic [2:0]         w_col;
    logic [2:0]         w_row;
    logic [3:0]         w_code;
    logic [GLYPH_W-1:0] w_bits;
    logic               w_glyph;
    logic               w_cursor;
    logic [3:0]         r_buf [N_CHARS];
    logic [BW-1:0]      r_blink_cnt;
    logic               r_blink_phase;
    logic               r_pixel_on;
    logic               r_vid_d;

    // Bounds are checked on the raw coordinates so pixels left of/above the origin never wrap into the box
    assign w_px     = 32'(bus.pixel_x);
    assign w_py     = 32'(bus.pixel_y);
    assign w_in_box = (w_px >= X0) && (w_px < X_END) && (w_py >= Y0) && (w_py < Y_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rel_x  <= '0;
            r_rel_y  <= '0;
            r_in_box <= 1'b0;
            r_vid    <= 1'b0;
        end else begin
            r_rel_x  <= 10'(w_px - X0);
            r_rel_y  <= 10'(w_py - Y0);
            r_in_box <= w_in_box;
            r_vid    <= bus.video_on;
        end
    end

    assign w_idx  = AW'(r_rel_x >> (SCALE_LOG2 + CELL_LOG2));
    assign w_col  = 3'(r_rel_x >> SCALE_LOG2);
    assign w_row  = 3'(r_rel_y >> SCALE_LOG2);
    assign w_code = (32'(w_idx) < N_CHARS) ? r_buf[w_idx] : GLYPH_BLANK;

    glyph_rom_5x6 u_rom (
        .code (w_code),
        .row  (w_row),
        .bits (w_bits)
    );

    assign w_glyph  = (w_col < 3'(GLYPH_W)) ? w_bits[3'd4 - w_col] : 1'b0;
    assign w_cursor = bus.cursor_en && r_blink_phase && (w_idx == bus.cursor_pos)
                   && (32'(bus.cursor_pos) < N_CHARS) && (w_row == 3'(CELL - 1)) && (w_col < 3'(GLYPH_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixel_on <= 1'b0;
            r_vid_d    <= 1'b0;
        end else begin
            r_pixel_on <= r_vid && r_in_box && (w_glyph || w_cursor);
            r_vid_d    <= r_vid;
        end
    end

    // Buffer is read combinationally in stage 2, so a same-cycle write is seen only on the next read
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CHARS; i++) r_buf[i] <= GLYPH_BLANK;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (bus.wr_en && (32'(bus.wr_addr) < N_CHARS)) r_buf[bus.wr_addr] <= bus.wr_data;
            if (bus.frame_tick) begin
                r_blink_cnt   <= (r_blink_cnt == BLINK_LAST) ? '0 : r_blink_cnt + 1'b1;
                r_blink_phase <= r_blink_phase ^ (r_blink_cnt == BLINK_LAST);
            end
        end
    end

    assign bus.pixel_on   = r_pixel_on;
    assign bus.video_on_d = r_vid_d;
endmodule

// File: tb/tb_digit_text_renderer.sv
// tb_digit_text_renderer: random pixel/write/cursor traffic on two renderer configurations against a font-level model
module tb_digit_text_renderer;
    localparam int NI     = 2;
    localparam int CYCLES = 30000;
    localparam int NC [NI] = '{8, 6};
    localparam int SL [NI] = '{1, 0};
    localparam int OX [NI] = '{16, 40};
    localparam int OY [NI] = '{16, 20};
    localparam int BF [NI] = '{30, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    int   mbuf   [NI][8];
    int   mticks [NI];
    bit   s1v    [NI];
    int   s1x    [NI];
    int   s1y    [NI];
    bit   e_pix  [NI];
    bit   e_vd   [NI];

    int   px, py, waddr, wdata, cpos;
    bit   vid, tick, wen, cen;

    always #5 clk = ~clk;

    digit_text_renderer_if #(.N_CHARS(8)) if0 ();
    digit_text_renderer_if #(.N_CHARS(6)) if1 ();

    digit_text_renderer u_dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (if0)
    );

    digit_text_renderer #(
        .N_CHARS      (6),
        .SCALE_LOG2   (0),
        .ORIGIN_X     (40),
        .ORIGIN_Y     (20),
        .BLINK_FRAMES (2)
    ) u_dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (if1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic bit font_px(input int c, input int r, input int col);
        string s;
        case (c)
            0:  s = {".###.", "#...#", "#...#", "#...#", "#...#", ".###."};
            1:  s = {"..#..", ".##..", "..#..", "..#..", "..#..", ".###."};
            2:  s = {".###.", "#...#", "...#.", "..#..", ".#...", "#####"};
            3:  s = {"####.", "....#", ".###.", "....#", "....#", "####."};
            4:  s = {"...#.", "..##.", ".#.#.", "#####", "...#.", "...#."};
            5:  s = {"#####", "#....", "####.", "....#", "#...#", ".###."};
            6:  s = {".###.", "#....", "####.", "#...#", "#...#", ".###."};
            7:  s = {"#####", "....#", "...#.", "..#..", ".#...", ".#..."};
            8:  s = {".###.", "#...#", ".###.", "#...#", "#...#", ".###."};
            9:  s = {".###.", "#...#", "#...#", ".####", "....#", ".###."};
            10: s = {".....", ".....", "#####", ".....", ".....", "....."};
            11: s = {".....", ".....", ".....", ".....", ".##..", ".##.."};
            12: s = {"#####", "#....", "####.", "#....", "#....", "#####"};
            default: return 1'b0;
        endcase
        return s[r * 5 + col] == "#";
    endfunction

    function automatic bit lit(input int i, input int x, input int y, input bit ce, input int cp);
        int sc, gx, gy, idx, col;
        sc = 1 << SL[i];
        if (x < OX[i] || x >= OX[i] + NC[i] * 8 * sc || y < OY[i] || y >= OY[i] + 8 * sc) return 1'b0;
        gx  = (x - OX[i]) / sc;
        gy  = (y - OY[i]) / sc;
        idx = gx / 8;
        col = gx % 8;
        if (gy < 6 && col < 5 && font_px(mbuf[i][idx], gy, col)) return 1'b1;
        return ce && ((mticks[i] / BF[i]) % 2 == 1) && cp == idx && gy == 7 && col < 5;
    endfunction

    // Expected outputs after the coming edge, then the state that edge leaves behind
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            e_vd[i]  = !rst && s1v[i] && vid == vid ? (!rst && s1v[i]) : 1'b0;
            e_pix[i] = !rst && s1v[i] && lit(i, s1x[i], s1y[i], cen, cpos);
            e_vd[i]  = !rst && s1v[i];
            if (rst) begin
                for (int a = 0; a < 8; a++) mbuf[i][a] = 15;
                mticks[i] = 0;
                s1v[i]    = 1'b0;
            end else begin
                if (wen && waddr < NC[i]) mbuf[i][waddr] = wdata;
                if (tick) mticks[i]++;
                s1v[i] = vid;
                s1x[i] = px;
                s1y[i] = py;
            end
        end
    endtask

    task automatic check_outputs();
        chk("pixel_on0", 32'(if0.pixel_on), 32'(e_pix[0]));
        chk("video_on_d0", 32'(if0.video_on_d), 32'(e_vd[0]));
        chk("pixel_on1", 32'(if1.pixel_on), 32'(e_pix[1]));
        chk("video_on_d1", 32'(if1.video_on_d), 32'(e_vd[1]));
    endtask

    initial begin
        for (int c = 0; c < CYCLES; c++) begin
            @(negedge clk);
            if (c > 0) check_outputs();
            rst   = (c < 3) || ($urandom_range(0, 1999) == 0);
            px    = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 159));
            py    = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(8, 39));
            vid   = $urandom_range(0, 7) != 0;
            tick  = $urandom_range(0, 3) == 0;
            wen   = $urandom_range(0, 3) == 0;
            waddr = int'($urandom_range(0, 7));
            wdata = int'($urandom_range(0, 15));
            cen   = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 63) == 0) cpos = int'($urandom_range(0, 7));
            if0.pixel_x = 10'(px);     if1.pixel_x = 10'(px);
            if0.pixel_y = 10'(py);     if1.pixel_y = 10'(py);
            if0.video_on = vid;        if1.video_on = vid;
            if0.frame_tick = tick;     if1.frame_tick = tick;
            if0.wr_en = wen;           if1.wr_en = wen;
            if0.wr_addr = 3'(waddr);   if1.wr_addr = 3'(waddr);
            if0.wr_data = 4'(wdata);   if1.wr_data = 4'(wdata);
            if0.cursor_en = cen;       if1.cursor_en = cen;
            if0.cursor_pos = 3'(cpos); if1.cursor_pos = 3'(cpos);
            model_step();
        end
        @(negedge clk);
        check_outputs();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
